// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into {op, payload} words for the
// RAM stage and serialises RAM read data back on MISO. Optional macro: SPI_TX_TIMEOUT_EN.
module spi_slave_if #(
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_TX_TIMEOUT_EN
  ,
  output logic                 tx_timeout
`endif
);

  // state     | meaning
  // IDLE      | SS_n high, waiting for a frame
  // CHK_CMD   | sample the command bit and pick the word state
  // WRITE     | receive a write word, then hold until SS_n rises
  // READ_ADD  | receive a read-address word, mark rd_addr_seen
  // READ_DATA | receive a read-data word, wait for tx_valid, serialise tx_data

  localparam int WORD_W = ADDR_SIZE + 2;
  localparam int CNT_W  = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Sub-phase inside the word states; WRITE and READ_ADD go SHIFT -> HOLD directly.
  typedef enum logic [1:0] {
    PH_SHIFT,
    PH_WAIT,
    PH_SER,
    PH_HOLD
  } phase_e;

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      ser_cnt_q, ser_cnt_d;
  logic [WORD_W-2:0]     shift_q, shift_d;
  logic [WORD_W-1:0]     rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic [ADDR_SIZE-1:0]  tx_shift_q, tx_shift_d;
  logic                  rd_addr_seen_q, rd_addr_seen_d;

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  tx_timeout_q, tx_timeout_d;
`else
  logic                  unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    bit_cnt_d      = bit_cnt_q;
    ser_cnt_d      = ser_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    tx_shift_d     = tx_shift_q;
    rd_addr_seen_d = rd_addr_seen_q;
`ifdef SPI_TX_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    tx_timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!SS_n) begin
          state_d   = CHK_CMD;
          phase_d   = PH_SHIFT;
          bit_cnt_d = '0;
          ser_cnt_d = '0;
        end
      end

      CHK_CMD: begin
        if (SS_n) begin
          state_d = IDLE;
        end else begin
          phase_d   = PH_SHIFT;
          bit_cnt_d = CNT_W'(WORD_W - 1);
          if (!MOSI)                state_d = WRITE;
          else if (!rd_addr_seen_q) state_d = READ_ADD;
          else                      state_d = READ_DATA;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_d = IDLE;
          phase_d = PH_SHIFT;
        end else begin
          case (phase_q)
            PH_SHIFT: begin
              shift_d = {shift_q[WORD_W-3:0], MOSI};
              if (bit_cnt_q == '0) begin
                rx_data_d  = {shift_q, MOSI};
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                if (state_q == READ_DATA) begin
                  rd_addr_seen_d = 1'b0;
                  phase_d        = PH_WAIT;
`ifdef SPI_TX_TIMEOUT_EN
                  to_cnt_d       = TO_W'(TIMEOUT_CYCLES - 1);
`endif
                end else begin
                  phase_d = PH_HOLD;
                end
              end else begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
              end
            end

            PH_WAIT: begin
              if (tx_valid) begin
                miso_d     = tx_data[ADDR_SIZE-1];
                tx_shift_d = {tx_data[ADDR_SIZE-2:0], 1'b0};
                ser_cnt_d  = CNT_W'(ADDR_SIZE - 1);
                phase_d    = PH_SER;
              end
`ifdef SPI_TX_TIMEOUT_EN
              else if (to_cnt_q == '0) begin
                tx_timeout_d = 1'b1;
                phase_d      = PH_HOLD;
              end else begin
                to_cnt_d = to_cnt_q - TO_W'(1);
              end
`endif
            end

            PH_SER: begin
              if (ser_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                ser_cnt_d  = ser_cnt_q - CNT_W'(1);
              end else begin
                phase_d = PH_HOLD;
              end
            end

            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= PH_SHIFT;
      bit_cnt_q      <= '0;
      ser_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      tx_shift_q     <= '0;
      rd_addr_seen_q <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      to_cnt_q       <= '0;
      tx_timeout_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      bit_cnt_q      <= bit_cnt_d;
      ser_cnt_q      <= ser_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      tx_shift_q     <= tx_shift_d;
      rd_addr_seen_q <= rd_addr_seen_d;
`ifdef SPI_TX_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      tx_timeout_q   <= tx_timeout_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_TX_TIMEOUT_EN
  assign tx_timeout = tx_timeout_q;
`endif

endmodule
